btn_event_io: RTL and testbench
===============================

# btn_event_io

Bus-attached button peripheral fed by the bus bridge's I/O port. It synchronises and debounces the five board push-buttons and exposes two registers to the CPU: the debounced level, and sticky press-event flags that the CPU clears with write-1-to-clear. It replaces polling of raw, bouncy button levels with clean edge events.

## Interface
Parameters:
- DEB_CYCLES, 200000 — consecutive stable cycles required to accept a new level (8 ms at 25 MHz); minimum 2.
- BTN_N, 5 — number of buttons.

Ports:
- clk  input  1  — CPU clock, forwarded by the bridge.
- rst  input  1  — asynchronous, active-high reset.
- addr  input  12  — low 12 bits of the bus address.
- wen  input  1  — write enable from the bridge; valid only in the same cycle as addr and wdata.
- wdata  input  32  — write data.
- button  input  BTN_N  — raw, asynchronous button pins, active-high.
- rdata  output  32  — read data; combinational from addr and registers.

## Operation
- **Synchroniser:** each button passes through 2 flops (sync1, sync2).
- **Debounce (per button):**
  - stable register plus counter of width clog2(DEB_CYCLES).
  - If sync2 == stable, the counter is cleared to 0.
  - If sync2 != stable and the counter < DEB_CYCLES-1, the counter increments.
  - If sync2 != stable and the counter == DEB_CYCLES-1, stable <= sync2 and the counter is cleared.
  - Any glitch back to the stable value restarts the count.
- **Press flags:**
  - press[i] is set when stable[i] goes 0→1. It stays set until cleared.
  - A bus write clears it: wen=1, addr=0x07C, wdata[i]=1. Writes with wdata bit 0 leave the flag unchanged.
  - If a set and a clear of the same bit occur in one cycle, set wins.
- **Read map:**
  - 0x078: {27'b0, stable[4:0]}.
  - 0x07C: {27'b0, press[4:0]}, plus release bits when configured.
  - Any other addr reads 32'h0.
- **Writes:**
  - A write to 0x078 is ignored.
  - A write to any other address is ignored.
- **Reset:** rst asserted clears sync1, sync2, stable, counters, and press flags (and release flags) immediately.
- **Reset mid-operation:**
  - Pending counts are lost.
  - A button held through reset is re-debounced from stable=0.
  - It therefore produces a fresh press event once accepted.

## Timing
- **Reset values:** all registers are 0. rdata is 0 for every address while in reset.
- **Press latency:** a clean raw rising edge sets stable 2 + DEB_CYCLES rising clk edges later. The press flag is visible one cycle after stable (registered on the stable transition).
- **Read latency:** reads are combinational; rdata is valid in the same cycle as addr.
- **Write-1-to-clear:** takes effect at the clk edge ending the write cycle. A read in the following cycle returns the cleared value.
- **Bounce rejection:** a pulse or bounce shorter than DEB_CYCLES cycles after synchronisation never changes stable.
- **Minimum DEB_CYCLES:** DEB_CYCLES=2 gives the minimum latency of 4 cycles to stable.

## Configuration
- Macro: BTN_RELEASE_EVT_EN.
- When defined:
  - Adds release[4:0], set on the stable 1→0 transition.
  - Readable at 0x07C bits [12:8].
  - Cleared by write-1 to wdata[12:8] at 0x07C, with the same set-wins rule.
- When undefined:
  - Bits [12:8] read 0.
  - Writes to bits [12:8] have no effect.
  - No release logic is synthesised.

## Structure
- **Shared package:**
  - BTN_LEVEL_ADDR = 12'h078.
  - BTN_EVT_ADDR = 12'h07C.
  - BTN_REL_LSB = 8.
  - Default DEB_CYCLES.
- **Sub-module btn_debounce_cell:**
  - One button.
  - Holds the synchroniser, counter and stable register.
  - Outputs stable, rise_pulse and fall_pulse.
  - The top generates BTN_N instances and holds the flag registers and read mux.

## Test plan
All scenarios use DEB_CYCLES=4.
1. **Reset:** assert rst asynchronously mid-cycle → all rdata reads are 0 immediately. Release rst with button=0 → 0x078 and 0x07C read 0.
2. **Clean press:** button=5'b00001 held → 0x078 reads 1 after 6 edges; 0x07C reads 1 one cycle later. Releasing → 0x078 returns to 0 after 6 edges; 0x07C stays 1.
3. **Bounce:** button[2] toggles 1,0,1,0 with 2-cycle pulses, then held 1 → stable[2] rises exactly once, 6 cycles after the final rise. press = 5'b00100.
4. **Write-1-to-clear:** with press=5'b10101, write 0x07C with wdata=32'h5 → next read returns 5'b10000. Write 0x078 with wdata=32'h1F → no change to either register.
5. **Simultaneous set and clear:** the clear write to 0x07C bit 3 lands in the same cycle stable[3] rises → press[3] reads 1.
6. **BTN_RELEASE_EVT_EN defined:** press then release button[1] → 0x07C reads 32'h0202. Write 32'h0200 → read returns 32'h0002.

Source files
------------

// File: rtl/btn_event_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_io_pkg
//  Purpose  : Shared register map and defaults for the button event peripheral.
//             The optional release-event feature is enabled by the
//             BTN_RELEASE_EVT_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
package btn_event_io_pkg;

    // Register map (low 12 bits of the bus address)
    localparam logic [11:0] BTN_LEVEL_ADDR = 12'h078;
    localparam logic [11:0] BTN_EVT_ADDR   = 12'h07C;

    // Bit position of the release flags inside the event register
    localparam int BTN_REL_LSB = 8;

    // 8 ms of stability at 25 MHz
    localparam int DEB_CYCLES_DEFAULT = 200000;
    localparam int BTN_N_DEFAULT      = 5;

endpackage : btn_event_io_pkg
`default_nettype wire

// File: rtl/btn_debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_cell
//  Purpose  : Two-flop synchroniser plus counter-based debouncer for a single
//             button. Emits the debounced level and one-cycle registered
//             pulses on accepted rising and falling transitions.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_cell
    import btn_event_io_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_stable,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int                c_cnt_w   = $clog2(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rise;
    logic               r_fall;
    logic               w_accept;

    // The new level has been held for the full window on this cycle
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == c_cnt_max);

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing cycles; any return to the stable level restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edge pulses are registered so event flags update one cycle after the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & r_sync2;
            r_fall <= w_accept & ~r_sync2;
        end
    end

    assign o_stable     = r_stable;
    assign o_rise_pulse = r_rise;
    assign o_fall_pulse = r_fall;

endmodule : btn_debounce_cell
`default_nettype wire

// File: rtl/btn_event_io.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_io
//  Purpose  : Bus-attached push-button peripheral. Debounces BTN_N buttons and
//             exposes the debounced level (0x078) and sticky write-1-to-clear
//             press flags (0x07C). Defining BTN_RELEASE_EVT_EN adds sticky
//             release flags at 0x07C bits [BTN_REL_LSB +: BTN_N].
//  Revision : 1.0 - initial release
// ============================================================================
module btn_event_io
    import btn_event_io_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int BTN_N      = BTN_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      addr,
    input  logic             wen,
    input  logic [31:0]      wdata,
    input  logic [BTN_N-1:0] button,
    output logic [31:0]      rdata
);

    logic [BTN_N-1:0] w_stable;
    logic [BTN_N-1:0] w_rise;
    logic [BTN_N-1:0] w_fall;
    logic             w_evt_wr;
    logic [BTN_N-1:0] w_press_clr;
    logic [BTN_N-1:0] r_press;
    logic [31:0]      w_evt_word;
    logic             w_unused;

    // One debouncer per button
    generate
        for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
            btn_debounce_cell #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .i_button     (button[gi]),
                .o_stable     (w_stable[gi]),
                .o_rise_pulse (w_rise[gi]),
                .o_fall_pulse (w_fall[gi])
            );
        end
    endgenerate

    assign w_evt_wr    = wen && (addr == BTN_EVT_ADDR);
    assign w_press_clr = w_evt_wr ? wdata[BTN_N-1:0] : '0;

    // Sticky press flags; a simultaneous rise overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press <= '0;
        end else begin
            r_press <= (r_press & ~w_press_clr) | w_rise;
        end
    end

`ifdef BTN_RELEASE_EVT_EN
    logic [BTN_N-1:0] w_release_clr;
    logic [BTN_N-1:0] r_release;

    assign w_release_clr = w_evt_wr ? wdata[BTN_REL_LSB +: BTN_N] : '0;

    // Sticky release flags; a simultaneous fall overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_release <= '0;
        end else begin
            r_release <= (r_release & ~w_release_clr) | w_fall;
        end
    end

    // Event register image with release flags
    always_comb begin
        w_evt_word                         = '0;
        w_evt_word[BTN_N-1:0]              = r_press;
        w_evt_word[BTN_REL_LSB +: BTN_N]   = r_release;
    end
`else
    // Event register image, press flags only
    always_comb begin
        w_evt_word            = '0;
        w_evt_word[BTN_N-1:0] = r_press;
    end
`endif

    // Combinational read mux; unmapped addresses read zero
    always_comb begin
        rdata = '0;
        case (addr)
            BTN_LEVEL_ADDR: rdata[BTN_N-1:0] = w_stable;
            BTN_EVT_ADDR:   rdata            = w_evt_word;
            default:        rdata            = '0;
        endcase
    end

    // Data bits with no storage behind them and edge pulses not always consumed
    assign w_unused = ^{wdata[31:BTN_N], w_fall};

endmodule : btn_event_io
`default_nettype wire

// File: tb/tb_btn_event_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event_io
//  Purpose  : Scoreboard bench for btn_event_io with DEB_CYCLES=4. Reads push
//             the expected value into a queue; a monitor pops and compares on
//             each read strobe. Expectations honour BTN_RELEASE_EVT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_io;
    import btn_event_io_pkg::*;

    localparam int DEB = 4;
    localparam int N   = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [11:0]   addr      = '0;
    logic          wen       = 1'b0;
    logic [31:0]   wdata     = '0;
    logic [N-1:0]  button    = '0;
    logic [31:0]   rdata;
    logic          rd_strobe = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [11:0] a;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    btn_event_io #(
        .DEB_CYCLES (DEB),
        .BTN_N      (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wen    (wen),
        .wdata  (wdata),
        .button (button),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    // Monitor: each read strobe consumes one scoreboard entry
    always @(posedge rd_strobe) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: read strobe with no expected entry, rdata=%h", rdata);
        end else begin
            e = sb.pop_front();
            if (rdata !== e.exp) begin
                n_fail++;
                $display("FAIL %s: addr=%h rdata=%h expected=%h", e.name, e.a, rdata, e.exp);
            end
        end
    end

    // Release-flag contribution to an expected event word
    function automatic logic [31:0] relb(input logic [31:0] x);
`ifdef BTN_RELEASE_EVT_EN
        return x;
`else
        return 32'h0 & x;
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
        exp_t item;
        item.name = nm;
        item.a    = a;
        item.exp  = e;
        addr = a;
        sb.push_back(item);
        #1 rd_strobe = 1'b1;
        #1 rd_strobe = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
        wdata = '0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(2);
        rd(BTN_LEVEL_ADDR, 32'h0, "rst_level");
        rd(BTN_EVT_ADDR,   32'h0, "rst_evt");
        rd(12'h000,        32'h0, "rst_other");
        tick();
        rst = 1'b0;
        tick(8);
        rd(BTN_LEVEL_ADDR, 32'h0, "idle_level");
        rd(BTN_EVT_ADDR,   32'h0, "idle_evt");

        // Clean press and release of button 0
        button = 5'b00001;
        tick(5);
        rd(BTN_LEVEL_ADDR, 32'h0, "press_early");
        tick();
        rd(BTN_LEVEL_ADDR, 32'h1, "press_level");
        rd(BTN_EVT_ADDR,   32'h0, "press_evt_lag");
        tick();
        rd(BTN_EVT_ADDR,   32'h1, "press_evt");
        button = 5'b00000;
        tick(5);
        rd(BTN_LEVEL_ADDR, 32'h1, "rel_early");
        tick();
        rd(BTN_LEVEL_ADDR, 32'h0, "rel_level");
        rd(BTN_EVT_ADDR,   32'h1, "rel_evt_sticky");
        tick();
        rd(BTN_EVT_ADDR,   32'h1 | relb(32'h100), "rel_evt_flags");
        wr(BTN_EVT_ADDR, 32'h101);
        rd(BTN_EVT_ADDR,   32'h0, "clr_b0");

        // Bounce on button 2: 2-cycle pulses never survive the window
        for (int k = 0; k < 4; k++) begin
            button = (k % 2 == 0) ? 5'b00100 : 5'b00000;
            tick(2);
            rd(BTN_LEVEL_ADDR, 32'h0, "bounce_hold");
        end
        button = 5'b00100;
        tick(5);
        rd(BTN_LEVEL_ADDR, 32'h0, "bounce_early");
        tick();
        rd(BTN_LEVEL_ADDR, 32'h4, "bounce_level");
        tick();
        rd(BTN_EVT_ADDR,   32'h4, "bounce_evt");
        button = 5'b00000;
        tick(7);
        rd(BTN_LEVEL_ADDR, 32'h0, "bounce_rel_level");
        rd(BTN_EVT_ADDR,   32'h4 | relb(32'h400), "bounce_rel_evt");

        // Write-1-to-clear with press = 10101 (press[2] still sticky)
        button = 5'b10001;
        tick(7);
        rd(BTN_EVT_ADDR,   32'h15 | relb(32'h400), "w1c_pre");
        rd(BTN_LEVEL_ADDR, 32'h11, "w1c_level");
        wr(BTN_EVT_ADDR, 32'h5);
        rd(BTN_EVT_ADDR,   32'h10 | relb(32'h400), "w1c_post");
        wr(BTN_LEVEL_ADDR, 32'h1F);
        rd(BTN_LEVEL_ADDR, 32'h11, "wlvl_level");
        rd(BTN_EVT_ADDR,   32'h10 | relb(32'h400), "wlvl_evt");
        wr(12'h080, 32'h1F1F);
        rd(BTN_EVT_ADDR,   32'h10 | relb(32'h400), "wother_evt");
        rd(12'h080,        32'h0, "other_rd");
        button = 5'b00000;
        tick(7);
        rd(BTN_EVT_ADDR,   32'h10 | relb(32'h1500), "w1c_rel_evt");
        wr(BTN_EVT_ADDR, 32'h1F1F);
        rd(BTN_EVT_ADDR,   32'h0, "clr_all_a");

        // Clear of press[3] in the same cycle as its set pulse: set wins
        button = 5'b01000;
        tick(6);
        rd(BTN_LEVEL_ADDR, 32'h8, "sim_level");
        wr(BTN_EVT_ADDR, 32'h8);
        rd(BTN_EVT_ADDR,   32'h8, "sim_setwins");
        wr(BTN_EVT_ADDR, 32'h8);
        rd(BTN_EVT_ADDR,   32'h0, "sim_clr");
        button = 5'b00000;
        tick(7);
        wr(BTN_EVT_ADDR, 32'h1F1F);
        rd(BTN_EVT_ADDR,   32'h0, "clr_all_b");

        // Press then release of button 1; release bits only when configured
        button = 5'b00010;
        tick(7);
        button = 5'b00000;
        tick(7);
        rd(BTN_EVT_ADDR,   32'h2 | relb(32'h200), "relcfg_evt");
        wr(BTN_EVT_ADDR, 32'h200);
        rd(BTN_EVT_ADDR,   32'h2, "relcfg_clr");
        wr(BTN_EVT_ADDR, 32'h2);
        rd(BTN_EVT_ADDR,   32'h0, "relcfg_clr_press");

        // Asynchronous reset mid-cycle with a button held through it
        button = 5'b00001;
        tick(7);
        rd(BTN_EVT_ADDR,   32'h1, "pre_rst_evt");
        tick();
        #3 rst = 1'b1;
        rd(BTN_LEVEL_ADDR, 32'h0, "rst_async_level");
        rd(BTN_EVT_ADDR,   32'h0, "rst_async_evt");
        tick(2);
        rst = 1'b0;
        tick(5);
        rd(BTN_LEVEL_ADDR, 32'h0, "redeb_early");
        tick();
        rd(BTN_LEVEL_ADDR, 32'h1, "redeb_level");
        tick();
        rd(BTN_EVT_ADDR,   32'h1, "redeb_evt");

        button = 5'b00000;
        tick(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_btn_event_io
`default_nettype wire
